// File: rtl/ir_ctrl_pkg.sv
// rtl/ir_ctrl_pkg.sv - shared state encoding, NEC key codes and key opcodes for the IR keypad controller
package ir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ENTER = 2'd1,
    OP_BACK  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  localparam logic [7:0] KEY_D0    = 8'h16;
  localparam logic [7:0] KEY_D1    = 8'h0C;
  localparam logic [7:0] KEY_D2    = 8'h18;
  localparam logic [7:0] KEY_D3    = 8'h5E;
  localparam logic [7:0] KEY_D4    = 8'h08;
  localparam logic [7:0] KEY_D5    = 8'h1C;
  localparam logic [7:0] KEY_D6    = 8'h5A;
  localparam logic [7:0] KEY_D7    = 8'h42;
  localparam logic [7:0] KEY_D8    = 8'h52;
  localparam logic [7:0] KEY_D9    = 8'h4A;
  localparam logic [7:0] KEY_ENTER = 8'h40;
  localparam logic [7:0] KEY_BACK  = 8'h44;
  localparam logic [7:0] KEY_CLEAR = 8'h45;

endpackage

// File: rtl/ir_key_ctrl_if.sv
// rtl/ir_key_ctrl_if.sv - frame input and keypad result bundle of the IR keypad controller
interface ir_key_ctrl_if;
  logic        i_frame_vld;
  logic [31:0] i_frame;
  logic [23:0] o_entry;
  logic [2:0]  o_entry_cnt;
  logic [23:0] o_value;
  logic        o_value_vld;
  logic        o_err;
  logic        o_drop;
  logic        o_busy;

  modport master (
    output i_frame_vld, i_frame,
    input  o_entry, o_entry_cnt, o_value, o_value_vld, o_err, o_drop, o_busy
  );

  modport slave (
    input  i_frame_vld, i_frame,
    output o_entry, o_entry_cnt, o_value, o_value_vld, o_err, o_drop, o_busy
  );
endinterface

// File: rtl/ir_key_dec.sv
// rtl/ir_key_dec.sv - combinational NEC command to digit/opcode decoder
module ir_key_dec
  import ir_ctrl_pkg::*;
(
  input  logic [7:0] command,
  output logic       is_digit,
  output logic [3:0] digit,
  output op_e        op,
  output logic       known
);

  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    op       = OP_NONE;
    case (command)
      KEY_D0:    begin is_digit = 1'b1; digit = 4'd0; end
      KEY_D1:    begin is_digit = 1'b1; digit = 4'd1; end
      KEY_D2:    begin is_digit = 1'b1; digit = 4'd2; end
      KEY_D3:    begin is_digit = 1'b1; digit = 4'd3; end
      KEY_D4:    begin is_digit = 1'b1; digit = 4'd4; end
      KEY_D5:    begin is_digit = 1'b1; digit = 4'd5; end
      KEY_D6:    begin is_digit = 1'b1; digit = 4'd6; end
      KEY_D7:    begin is_digit = 1'b1; digit = 4'd7; end
      KEY_D8:    begin is_digit = 1'b1; digit = 4'd8; end
      KEY_D9:    begin is_digit = 1'b1; digit = 4'd9; end
      KEY_ENTER: op = OP_ENTER;
      KEY_BACK:  op = OP_BACK;
      KEY_CLEAR: op = OP_CLEAR;
      default:   ;
    endcase
    known = is_digit || (op != OP_NONE);
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// rtl/ir_key_ctrl.sv - NEC IR keypad controller: validates frames, edits a six-digit BCD entry,
// commits it on ENTER and locks out further frames for a hold period after each command
module ir_key_ctrl
  import ir_ctrl_pkg::*;
#(
  parameter logic [7:0]  P_ADDR     = 8'h00,
  parameter logic [31:0] P_HOLD_CYC = 32'd5_000_000
)
(
  input  logic        clk,
  input  logic        rst_n,
  ir_key_ctrl_if.slave bus
);

  // A zero hold length still yields one HOLD cycle instead of wrapping the counter
  localparam logic [31:0] LP_HOLD_LOAD = (P_HOLD_CYC == 32'd0) ? 32'd0 : P_HOLD_CYC - 32'd1;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_frame;
  logic [31:0] r_hold_cnt, w_hold_nxt;
  logic [23:0] r_entry, w_entry_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [23:0] r_value, w_value_nxt;
  logic        r_value_vld, w_value_vld_nxt;
  logic        r_err, w_err_nxt;
  logic        r_drop, w_drop_nxt;

  logic        w_is_digit;
  logic [3:0]  w_digit;
  op_e         w_op;
  logic        w_known;
  logic        w_frame_ok;

  ir_key_dec u_dec (
    .command  (r_frame[15:8]),
    .is_digit (w_is_digit),
    .digit    (w_digit),
    .op       (w_op),
    .known    (w_known)
  );

  assign w_frame_ok = (r_frame[31:24] == P_ADDR)
                   && (r_frame[31:24] == ~r_frame[23:16])
                   && (r_frame[15:8]  == ~r_frame[7:0])
                   && w_known;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_frame_vld) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = w_frame_ok ? ST_EXEC : ST_IDLE;
      ST_EXEC:  w_state_nxt = ST_HOLD;
      ST_HOLD:  if (r_hold_cnt == 32'd0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_entry_nxt     = r_entry;
    w_cnt_nxt       = r_cnt;
    w_value_nxt     = r_value;
    w_hold_nxt      = r_hold_cnt;
    w_value_vld_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    w_drop_nxt      = bus.i_frame_vld && (r_state != ST_IDLE);
    case (r_state)
      ST_CHECK: w_err_nxt = !w_frame_ok;
      ST_EXEC: begin
        w_hold_nxt = LP_HOLD_LOAD;
        if (w_is_digit) begin
          if (r_cnt < 3'd6) begin
            w_entry_nxt = {r_entry[19:0], w_digit};
            w_cnt_nxt   = r_cnt + 3'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          case (w_op)
            OP_ENTER: begin
              w_value_nxt     = r_entry;
              w_value_vld_nxt = 1'b1;
              w_entry_nxt     = 24'h0;
              w_cnt_nxt       = 3'd0;
            end
            OP_BACK: if (r_cnt != 3'd0) begin
              w_entry_nxt = {4'h0, r_entry[23:4]};
              w_cnt_nxt   = r_cnt - 3'd1;
            end
            OP_CLEAR: begin
              w_entry_nxt = 24'h0;
              w_cnt_nxt   = 3'd0;
            end
            default: ;
          endcase
        end
      end
      ST_HOLD: if (r_hold_cnt != 32'd0) w_hold_nxt = r_hold_cnt - 32'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame     <= 32'h0;
      r_hold_cnt  <= 32'h0;
      r_entry     <= 24'h0;
      r_cnt       <= 3'd0;
      r_value     <= 24'h0;
      r_value_vld <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.i_frame_vld) r_frame <= bus.i_frame;
      r_hold_cnt  <= w_hold_nxt;
      r_entry     <= w_entry_nxt;
      r_cnt       <= w_cnt_nxt;
      r_value     <= w_value_nxt;
      r_value_vld <= w_value_vld_nxt;
      r_err       <= w_err_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  assign bus.o_entry     = r_entry;
  assign bus.o_entry_cnt = r_cnt;
  assign bus.o_value     = r_value;
  assign bus.o_value_vld = r_value_vld;
  assign bus.o_err       = r_err;
  assign bus.o_drop      = r_drop;
  assign bus.o_busy      = (r_state != ST_IDLE);

endmodule
